// File: rtl/life_grid_if.sv
// Host-side bus of the life_grid engine: seed loading, step handshake,
// status (busy/done/generation count) and registered row readout.
interface life_grid_if #(
  parameter int COLS  = 8,
  parameter int ROW_W = 3,
  parameter int GEN_W = 16
) ();
  logic             load_valid;
  logic [ROW_W-1:0] load_row;
  logic [COLS-1:0]  load_data;
  logic             load_ready;
  logic             step_valid;
  logic             step_ready;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_count;
  logic [ROW_W-1:0] rd_row;
  logic [COLS-1:0]  rd_data;

  modport master (
    output load_valid, load_row, load_data, step_valid, rd_row,
    input  load_ready, step_ready, busy, done, gen_count, rd_data
  );

  modport slave (
    input  load_valid, load_row, load_data, step_valid, rd_row,
    output load_ready, step_ready, busy, done, gen_count, rd_data
  );
endinterface

// File: rtl/life_grid.sv
// Game-of-Life engine: one row per cycle into a shadow buffer, whole-grid commit.
// Define LIFE_WRAP_EN for a toroidal grid; otherwise cells outside the grid are dead.
module life_grid #(
  parameter int         COLS         = 8,
  parameter int         ROWS         = 8,
  parameter int         ROW_W        = 3,
  parameter int         GEN_W        = 16,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
  input logic       clk,
  input logic       rst,
  life_grid_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row_ptr;
  logic [COLS-1:0]  grid   [ROWS];
  logic [COLS-1:0]  shadow [ROWS];
  logic [COLS-1:0]  row_up, row_mid, row_dn, row_next;
  logic [COLS+1:0]  ext_up, ext_mid, ext_dn;
  logic             load_fire;

  // Pads a row with its column -1 and column COLS neighbours.
  function automatic logic [COLS+1:0] extend(input logic [COLS-1:0] row);
`ifdef LIFE_WRAP_EN
    return {row[0], row, row[COLS-1]};
`else
    return {1'b0, row, 1'b0};
`endif
  endfunction

  always_comb begin
    row_mid = grid[row_ptr];
    row_up  = '0;
    row_dn  = '0;
`ifdef LIFE_WRAP_EN
    row_up = (row_ptr == '0)       ? grid[LAST_ROW] : grid[row_ptr - ROW_W'(1)];
    row_dn = (row_ptr == LAST_ROW) ? grid[0]        : grid[row_ptr + ROW_W'(1)];
`else
    if (row_ptr != '0)       row_up = grid[row_ptr - ROW_W'(1)];
    if (row_ptr != LAST_ROW) row_dn = grid[row_ptr + ROW_W'(1)];
`endif
  end

  assign ext_up  = extend(row_up);
  assign ext_mid = extend(row_mid);
  assign ext_dn  = extend(row_dn);

  // Column c of the padded rows sits at bit c+1.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [3:0] n;
    assign n = 4'(ext_up[c]) + 4'(ext_up[c+1]) + 4'(ext_up[c+2])
             + 4'(ext_mid[c])                  + 4'(ext_mid[c+2])
             + 4'(ext_dn[c]) + 4'(ext_dn[c+1]) + 4'(ext_dn[c+2]);
    assign row_next[c] = row_mid[c] ? SURVIVE_MASK[n] : BIRTH_MASK[n];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.load_ready = 1'b0;
    bus.step_ready = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      IDLE: begin
        bus.load_ready = 1'b1;
        bus.step_ready = 1'b1;
        if (bus.step_valid) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        bus.busy = 1'b1;
        if (row_ptr == LAST_ROW) state_nxt = COMMIT;
      end
      COMMIT: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_fire = bus.load_valid & bus.load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_ptr       <= '0;
      bus.gen_count <= '0;
    end else begin
      if (state == COMPUTE) row_ptr <= (row_ptr == LAST_ROW) ? '0 : row_ptr + ROW_W'(1);
      if (state == COMMIT)  bus.gen_count <= bus.gen_count + GEN_W'(1);
    end
  end

  // Commit and load are mutually exclusive because loads are only accepted in IDLE.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    always_ff @(posedge clk) begin
      if (rst) begin
        grid[r]   <= '0;
        shadow[r] <= '0;
      end else begin
        if (state == COMMIT)
          grid[r] <= shadow[r];
        else if (load_fire && bus.load_row == ROW_W'(r))
          grid[r] <= bus.load_data;
        if (state == COMPUTE && row_ptr == ROW_W'(r))
          shadow[r] <= row_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      bus.rd_data <= '0;
    else if ({1'b0, bus.rd_row} < (ROW_W+1)'(ROWS))
      bus.rd_data <= grid[bus.rd_row];
    else
      bus.rd_data <= '0;
  end

endmodule

// File: tb/tb_life_grid.sv
// Scoreboard bench for life_grid: stimulus pushes model predictions, a monitor
// pops them on every done pulse and reads the committed grid back.
module tb_life_grid;
  localparam int COLS  = 8;
  localparam int ROWS  = 8;
  localparam int ROW_W = 3;
  localparam int GEN_W = 16;
  localparam int N     = ROWS * COLS;
  localparam int IW    = $clog2(N);
  localparam logic [8:0] B3  = 9'b000001000;
  localparam logic [8:0] S23 = 9'b000001100;

  typedef logic [N-1:0] flat_t;
  typedef struct {
    flat_t            grid;
    logic [GEN_W-1:0] gen;
    int               t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  life_grid_if #(.COLS(COLS), .ROW_W(ROW_W), .GEN_W(GEN_W)) bus ();
  life_grid_if #(.COLS(COLS), .ROW_W(ROW_W), .GEN_W(4))     bus2 ();

  life_grid #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .GEN_W(GEN_W),
              .BIRTH_MASK(B3), .SURVIVE_MASK(S23))
    dut (.clk(clk), .rst(rst), .bus(bus));

  life_grid #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .GEN_W(4),
              .BIRTH_MASK(9'b000000010), .SURVIVE_MASK(9'b000000000))
    dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               mon_cnt = 0;
  exp_t             q[$];
  flat_t            mg = '0;
  logic [GEN_W-1:0] mgen = '0;
  flat_t            last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [COLS-1:0] row_of(input flat_t g, input int r);
    return g[IW'(r*COLS) +: COLS];
  endfunction

  // Reference generation: count the eight neighbours of every cell directly.
  function automatic flat_t life_next(input flat_t g, input logic [8:0] bm, input logic [8:0] sm);
    flat_t nx = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
`ifdef LIFE_WRAP_EN
            rr = (rr + ROWS) % ROWS;
            cc = (cc + COLS) % COLS;
`else
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) continue;
`endif
            n += int'(g[IW'(rr*COLS + cc)]);
          end
        end
        nx[IW'(r*COLS + c)] = g[IW'(r*COLS + c)] ? sm[4'(n)] : bm[4'(n)];
      end
    end
    return nx;
  endfunction

  initial begin : monitor
    exp_t  e;
    flat_t got;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=%b with no step outstanding, expected 0", bus.done);
        end else begin
          e = q.pop_front();
          chk("done_latency", 64'(cyc - e.t), 64'(ROWS + 1));
          @(negedge clk);
          chk("gen_count", 64'(bus.gen_count), 64'(e.gen));
          got = '0;
          for (int r = 0; r < ROWS; r++) begin
            bus.rd_row = ROW_W'(r);
            @(negedge clk);
            got[IW'(r*COLS) +: COLS] = bus.rd_data;
          end
          chk("grid", 64'(got), 64'(e.grid));
          last_rd = got;
          mon_cnt++;
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (bus.step_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: step_ready=%b, expected 1", bus.step_ready);
    end
  endtask

  task automatic wait_mon(input int base);
    int k = 0;
    while (mon_cnt == base && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (mon_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL step_timeout: monitor count %0d, expected %0d", mon_cnt, base + 1);
    end
  endtask

  task automatic load(input int r, input logic [COLS-1:0] d);
    bus.load_valid = 1'b1;
    bus.load_row   = ROW_W'(r);
    bus.load_data  = d;
    @(negedge clk);
    bus.load_valid = 1'b0;
    mg[IW'(r*COLS) +: COLS] = d;
  endtask

  task automatic load_grid(input flat_t g);
    for (int r = 0; r < ROWS; r++) load(r, g[IW'(r*COLS) +: COLS]);
  endtask

  task automatic do_step(input bit with_load, input int lr, input logic [COLS-1:0] ld);
    int base;
    wait_idle();
    base = mon_cnt;
    bus.step_valid = 1'b1;
    if (with_load) begin
      bus.load_valid = 1'b1;
      bus.load_row   = ROW_W'(lr);
      bus.load_data  = ld;
      mg[IW'(lr*COLS) +: COLS] = ld;
    end
    mg   = life_next(mg, B3, S23);
    mgen = mgen + 1'b1;
    q.push_back('{mg, mgen, cyc});
    @(negedge clk);
    bus.step_valid = 1'b0;
    bus.load_valid = 1'b0;
    wait_mon(base);
  endtask

  task automatic step2();
    int k = 0;
    bus2.step_valid = 1'b1;
    @(negedge clk);
    bus2.step_valid = 1'b0;
    while (bus2.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      checks++;
      errors++;
      $display("FAIL step2_timeout: done=%b, expected 1", bus2.done);
    end
    @(negedge clk);
  endtask

  task automatic read2(input int r, output logic [COLS-1:0] d);
    bus2.rd_row = ROW_W'(r);
    @(negedge clk);
    d = bus2.rd_data;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    flat_t           seed;
    flat_t           rnd;
    int              base;
    logic [COLS-1:0] d;

    bus.load_valid = 1'b0; bus.load_row = '0; bus.load_data = '0;
    bus.step_valid = 1'b0; bus.rd_row = '0;
    bus2.load_valid = 1'b0; bus2.load_row = '0; bus2.load_data = '0;
    bus2.step_valid = 1'b0; bus2.rd_row = '0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_gen", 64'(bus.gen_count), 64'(0));
    chk("rst_rd_data", 64'(bus.rd_data), 64'(0));
    chk("rst_load_ready", 64'(bus.load_ready), 64'(1));
    chk("rst_step_ready", 64'(bus.step_ready), 64'(1));
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);

    // Blinker oscillates with period 2.
    seed = '0;
    seed[IW'(3*COLS) +: COLS] = 8'b00010000;
    seed[IW'(4*COLS) +: COLS] = 8'b00010000;
    seed[IW'(5*COLS) +: COLS] = 8'b00010000;
    load_grid(seed);
    do_step(1'b0, 0, '0);
    chk("blinker_row4", 64'(row_of(last_rd, 4)), 64'(8'b00111000));
    chk("blinker_row3", 64'(row_of(last_rd, 3)), 64'(0));
    chk("blinker_row5", 64'(row_of(last_rd, 5)), 64'(0));
    do_step(1'b0, 0, '0);
    chk("blinker_back", 64'(last_rd), 64'(seed));

    // Block still life.
    seed = '0;
    seed[IW'(2*COLS) +: COLS] = 8'b00011000;
    seed[IW'(3*COLS) +: COLS] = 8'b00011000;
    load_grid(seed);
    for (int i = 0; i < 5; i++) do_step(1'b0, 0, '0);
    chk("block_still", 64'(last_rd), 64'(seed));

    // Glider from the top-left corner.
    seed = '0;
    seed[IW'(0*COLS) +: COLS] = 8'b00000010;
    seed[IW'(1*COLS) +: COLS] = 8'b00000100;
    seed[IW'(2*COLS) +: COLS] = 8'b00000111;
    load_grid(seed);
    for (int i = 0; i < 32; i++) do_step(1'b0, 0, '0);
`ifdef LIFE_WRAP_EN
    chk("glider_wrap", 64'(last_rd), 64'(seed));
`else
    checks++;
    if (last_rd === seed) begin
      errors++;
      $display("FAIL glider_nowrap: grid %0h equals the seed, expected a different grid", last_rd);
    end
`endif

    // Random grids, including a load accepted together with a step.
    for (int round = 0; round < 4; round++) begin
      rnd = {$urandom, $urandom};
      load_grid(rnd);
      do_step(1'b0, 0, '0);
      do_step(1'b1, int'($urandom_range(0, ROWS - 1)), COLS'($urandom));
      do_step(1'b0, 0, '0);
    end

    // Load and step while busy are ignored.
    rnd = {$urandom, $urandom};
    rnd[IW'(0) +: COLS] = 8'h00;
    load_grid(rnd);
    wait_idle();
    base = mon_cnt;
    bus.step_valid = 1'b1;
    mg   = life_next(mg, B3, S23);
    mgen = mgen + 1'b1;
    q.push_back('{mg, mgen, cyc});
    @(negedge clk);
    bus.step_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_load_ready", 64'(bus.load_ready), 64'(0));
    chk("busy_step_ready", 64'(bus.step_ready), 64'(0));
    bus.load_valid = 1'b1;
    bus.load_row   = '0;
    bus.load_data  = 8'hFF;
    bus.step_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.step_valid = 1'b0;
    wait_mon(base);
    chk("busy_row0", 64'(row_of(last_rd, 0)), 64'(row_of(mg, 0)));
    repeat (15) @(negedge clk);
    chk("busy_single_done", 64'(mon_cnt), 64'(base + 1));

    // Reset during compute abandons the generation.
    load_grid({$urandom, $urandom});
    wait_idle();
    bus.step_valid = 1'b1;
    @(negedge clk);
    bus.step_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy), 64'(0));
    chk("midrst_gen", 64'(bus.gen_count), 64'(0));
    chk("midrst_done", 64'(bus.done), 64'(0));
    chk("midrst_rd_data", 64'(bus.rd_data), 64'(0));
    rst = 1'b0;
    mg = '0;
    mgen = '0;
    repeat (12) @(negedge clk);
    do_step(1'b0, 0, '0);

    // B1/S0 rule with a 4-bit generation counter.
    bus2.load_valid = 1'b1;
    bus2.load_row   = 3'd4;
    bus2.load_data  = 8'b00010000;
    @(negedge clk);
    bus2.load_valid = 1'b0;
    step2();
    chk("b1_gen1", 64'(bus2.gen_count), 64'(1));
    read2(2, d); chk("b1_row2", 64'(d), 64'(0));
    read2(3, d); chk("b1_row3", 64'(d), 64'(8'b00111000));
    read2(4, d); chk("b1_row4", 64'(d), 64'(8'b00101000));
    read2(5, d); chk("b1_row5", 64'(d), 64'(8'b00111000));
    read2(6, d); chk("b1_row6", 64'(d), 64'(0));
    for (int i = 1; i < 15; i++) step2();
    chk("gen_15", 64'(bus2.gen_count), 64'(15));
    step2();
    chk("gen_wrap", 64'(bus2.gen_count), 64'(0));

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_grid.md
Name: life_grid

Overview:
- Parametrised Game-of-Life engine holding a full ROWS x COLS cell grid in registers.
- Advances the grid one generation per step command using a configurable birth/survive rule.
- Computes one row per cycle into a shadow buffer, then commits the whole buffer at once.
- Sits behind the demo controller: the host loads the seed rows, issues steps and reads rows back for display.

Parameters:
- COLS, 8, cells per row (width of row data).
- ROWS, 8, number of rows (>= 3).
- ROW_W, 3, row index width; must satisfy 2**ROW_W >= ROWS.
- GEN_W, 16, generation counter width.
- BIRTH_MASK, 9'b000001000, bit n set => dead cell with n live neighbours becomes live (default B3).
- SURVIVE_MASK, 9'b000001100, bit n set => live cell with n live neighbours stays live (default S23).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- load_valid  in  1  write load_data into row load_row.
- load_row  in  ROW_W  target row index for load.
- load_data  in  COLS  row contents; bit c = cell in column c.
- load_ready  out  1  high when idle; a load is accepted only when load_valid & load_ready.
- step_valid  in  1  request one generation.
- step_ready  out  1  high when idle.
- busy  out  1  high while a generation is being computed or committed.
- done  out  1  one-cycle pulse on the commit cycle.
- gen_count  out  GEN_W  number of committed generations since reset.
- rd_row  in  ROW_W  row index to read.
- rd_data  out  COLS  registered contents of the committed grid at rd_row.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high. While rst is high at an edge:
  - grid and shadow buffer are cleared to 0;
  - gen_count = 0, busy = 0, done = 0, rd_data = 0, row pointer = 0;
  - state = IDLE.
  - Reset mid-operation abandons the generation: no commit, gen_count stays 0.
- States:
  - IDLE: load_ready = step_ready = 1, busy = 0.
  - COMPUTE: busy = 1; row pointer r runs 0..ROWS-1, one row per cycle.
  - COMMIT: busy = 1, done = 1, for one cycle.
- Transitions:
  - IDLE -> COMPUTE on step_valid.
  - COMPUTE -> COMMIT after row ROWS-1.
  - COMMIT -> IDLE.
  - Step latency: accept edge + ROWS compute cycles + 1 commit cycle. done is asserted ROWS+1 cycles after the accepting edge.
- Per-cell rule in COMPUTE, row r, column c:
  - n = sum of the 8 neighbours from the committed grid; 4-bit unsigned, range 0..8.
  - If the cell is live, next = SURVIVE_MASK[n]; otherwise next = BIRTH_MASK[n].
  - Result is written to shadow row r.
  - The committed grid is never modified during COMPUTE, so update order cannot matter.
- Edge handling: neighbour coordinates wrap modulo ROWS/COLS (toroidal) or are treated as dead, per the optional feature below.
- COMMIT:
  - grid <= shadow (all rows in one edge);
  - gen_count <= gen_count + 1, wrapping to 0 at 2**GEN_W.
- Load:
  - Accepted only in IDLE; grid[load_row] <= load_data.
  - load_valid while busy is ignored (no effect, not queued).
  - load_row >= ROWS is ignored.
- Simultaneous load and step in IDLE: both are accepted. The load writes the grid at the same edge, and the step computes on the post-load grid.
- step_valid while busy is ignored, not queued.
- Read path:
  - rd_data <= grid[rd_row] every cycle, one-cycle latency.
  - Reads during COMPUTE return the pre-step grid.
  - Out-of-range rd_row returns 0.

Optional Feature:
- Macro: LIFE_WRAP_EN.
- Defined: toroidal grid. Row -1 maps to ROWS-1, row ROWS to 0, and likewise for columns.
- Undefined: cells outside the grid are constant dead; edge cells see fewer than 8 real neighbours.

Test Plan:
- Blinker: 8x8, rows 3,4,5 = 8'b00010000, one step. Required: row 4 = 8'b00111000, rows 3 and 5 = 0, done pulse, gen_count = 1. A second step restores the original rows; gen_count = 2.
- Still life: block at rows 2–3 = 8'b00011000, 5 steps. Grid unchanged; gen_count = 5; done pulse ROWS+1 = 9 cycles after each accepting edge.
- Glider wrap (LIFE_WRAP_EN defined): glider at the top-left corner, 32 steps on 8x8. Grid equals the initial seed. Without the macro, the glider dies or turns into a still block at the corner; the grid never equals the seed.
- Busy rejection: step accepted; on cycle 3 drive load_valid (row 0 = 8'hFF) and step_valid. Required: load_ready = 0 and step_ready = 0 on cycle 3, row 0 unchanged after commit, exactly one done pulse, gen_count +1.
- Reset mid-compute: assert rst on compute cycle 4. Required next cycle: grid all 0, gen_count = 0, busy = 0, no done pulse.
- Custom rule and counter wrap: BIRTH_MASK = 9'b000000010 (B1), SURVIVE_MASK = 0, GEN_W = 4; single live cell at (4,4). After 1 step: cell dead, its 8 neighbours live. After 16 steps: gen_count = 0.
